f_fetch_pc: RTL and testbench
=============================

# f_fetch_pc

Fetch-stage program counter and F/D pipeline register for the five-stage MIPS core. Consumes the decode-stage redirect decisions (branch-taken from the D-stage comparator, j/jal, jr) and produces the next fetch address. It latches the fetched instruction into the D stage, honouring pipeline stalls. The block is the receiving end of the branch-decision path: the comparator decides, this block acts.

## Interface
- PC_RESET, 32'h0000_3000, fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; low forces all state to reset values
- stall  in  1  hazard-unit stall; 1 holds PC and F/D register
- B_jump  in  1  D-stage branch taken (already qualified by branch type)
- Is_J  in  1  D-stage instruction is j or jal
- Is_JR  in  1  D-stage instruction is jr or jalr
- rs_data  in  32  forwarded GPR[rs] value for jr targets
- IM_instr  in  32  instruction read combinationally from IM at F_pc
- F_pc  out  32  current fetch address (to IM)
- D_instr  out  32  instruction held in D
- D_pc  out  32  address of D_instr
- D_pc8  out  32  D_pc + 8 (link value for jal/jalr)
- D_valid  out  1  D holds a real instruction (0 = bubble)
- pc_misalign  out  1  sticky: a jr target had nonzero bits [1:0]

## Operation
- Registers: PC (32), D_instr (32), D_pc (32), D_valid (1), pc_misalign (1).
- Reset values: PC = PC_RESET, D_instr = 0, D_pc = 0, D_valid = 0, pc_misalign = 0; D_pc8 = 8 combinationally.
- Redirect targets, computed from registered D_instr/D_pc, with 32-bit wrap-around:
  - branch: D_pc + 4 + (sign-extended D_instr[15:0] << 2)
  - j: {(D_pc + 4)[31:28], D_instr[25:0], 2'b00}
  - jr: {rs_data[31:2], 2'b00}
- Next-PC priority: stall (hold) > Is_JR > Is_J > B_jump > PC + 4. Simultaneous redirect flags resolve by this priority without error.
- Redirects act only when D_valid = 1. A bubble in D never redirects.
- On a non-stalled edge with Is_JR = 1, D_valid = 1 and rs_data[1:0] != 0: pc_misalign sets. It is cleared only by reset.
- Stall = 1: PC, D_instr, D_pc and D_valid all hold. A pending redirect is re-evaluated on the next non-stalled cycle, because D is unchanged.
- Normal non-stalled edge: D_instr <= IM_instr, D_pc <= PC, D_valid <= 1.
- PC + 4 at 32'hFFFF_FFFC wraps to 0.

## Timing
- F_pc is a register output. IM read and all next-PC logic are combinational within one cycle.
- Redirect latency: a target decided in D becomes F_pc on the next rising edge. The first target instruction reaches D one edge later.
- With delay slot: the instruction fetched alongside the branch executes.
- Without delay slot: that instruction is squashed, costing one bubble.
- Reset assertion mid-operation: outputs go to reset values immediately, independent of clk. On deassertion, the first edge loads D from PC_RESET.

## Configuration
- F_FETCH_PC_DELAY_SLOT_EN defined (default build): MIPS delay-slot semantics. On a taken redirect, F/D loads IM_instr and F_pc normally; D_valid = 1.
- Undefined: on a non-stalled edge with a taken redirect, F/D loads D_instr = 0, D_pc = PC and D_valid = 0. This squashes the wrong-path instruction.
- PC update is identical in both builds.

## Test plan
- Reset low, then release. Seq instrs at 0x3000, 0x3004 -> F_pc 0x3000, 0x3004, 0x3008. D_pc lags one cycle. D_valid 0 then 1. D_pc8 = D_pc + 8.
- beq in D at D_pc 0x3004, imm16 0xFFFF, B_jump 1 -> next F_pc 0x3004. Delay-slot build: D gets the instr at 0x3008, D_valid 1. Other build: D_instr 0, D_valid 0.
- j with index 0x0000C10 at D_pc 0x3010, plus jr with rs_data 0x0000_3040, both asserted together -> F_pc 0x3040 (jr wins). pc_misalign stays 0.
- stall held 3 cycles with B_jump 1 -> F_pc, D_instr, D_pc unchanged for 3 edges. On the first non-stalled edge, F_pc = branch target.
- jr with rs_data 0x0000_3006 -> F_pc 0x3004 and pc_misalign 1. pc_misalign stays 1 until reset low clears it asynchronously, mid-cycle; F_pc returns to 0x3000.

Source files
------------

// File: rtl/f_fetch_pc_if.sv
// Fetch/decode bundle between f_fetch_pc and the rest of the core.
// master = fetch block, slave = decode/hazard/IM side.
interface f_fetch_pc_if;
  logic        stall;
  logic        B_jump;
  logic        Is_J;
  logic        Is_JR;
  logic [31:0] rs_data;
  logic [31:0] IM_instr;
  logic [31:0] F_pc;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic [31:0] D_pc8;
  logic        D_valid;
  logic        pc_misalign;

  modport master (
    input  stall, B_jump, Is_J, Is_JR,
    input  rs_data, IM_instr,
    output F_pc, D_instr, D_pc, D_pc8,
    output D_valid, pc_misalign
  );

  modport slave (
    output stall, B_jump, Is_J, Is_JR,
    output rs_data, IM_instr,
    input  F_pc, D_instr, D_pc, D_pc8,
    input  D_valid, pc_misalign
  );
endinterface

// File: rtl/f_fetch_pc.sv
// Fetch PC and F/D register; F_FETCH_PC_DELAY_SLOT_EN selects
// delay-slot semantics, otherwise wrong-path fetch is squashed.
module f_fetch_pc #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic         clk,
  input  logic         reset,
  f_fetch_pc_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] dpc_q, dpc_d;
  logic        dvalid_q, dvalid_d;
  logic        mis_q, mis_d;

  logic [31:0] pc_plus4;
  logic [31:0] dpc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic        take_jr;
  logic        take_j;
  logic        take_b;
  logic        redirect;

  assign pc_plus4  = pc_q + 32'd4;
  assign dpc_plus4 = dpc_q + 32'd4;
  assign br_tgt    = dpc_plus4
                   + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign j_tgt     = {dpc_plus4[31:28], instr_q[25:0], 2'b00};
  assign jr_tgt    = {bus.rs_data[31:2], 2'b00};

  // Flags made one-hot here so the selector below stays unique.
  assign take_jr  = dvalid_q & bus.Is_JR;
  assign take_j   = dvalid_q & bus.Is_J & ~bus.Is_JR;
  assign take_b   = dvalid_q & bus.B_jump
                  & ~bus.Is_J & ~bus.Is_JR;
  assign redirect = take_jr | take_j | take_b;

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    dpc_d    = dpc_q;
    dvalid_d = dvalid_q;
    mis_d    = mis_q;
    if (!bus.stall) begin
      unique case (1'b1)
        take_jr: pc_d = jr_tgt;
        take_j:  pc_d = j_tgt;
        take_b:  pc_d = br_tgt;
        default: pc_d = pc_plus4;
      endcase
      if (take_jr && (bus.rs_data[1:0] != 2'b00))
        mis_d = 1'b1;
      instr_d  = bus.IM_instr;
      dpc_d    = pc_q;
      dvalid_d = 1'b1;
`ifdef F_FETCH_PC_DELAY_SLOT_EN
`else
      if (redirect) begin
        instr_d  = 32'd0;
        dvalid_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= PC_RESET;
      instr_q  <= 32'd0;
      dpc_q    <= 32'd0;
      dvalid_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      dpc_q    <= dpc_d;
      dvalid_q <= dvalid_d;
      mis_q    <= mis_d;
    end
  end

  assign bus.F_pc        = pc_q;
  assign bus.D_instr     = instr_q;
  assign bus.D_pc        = dpc_q;
  assign bus.D_pc8       = dpc_q + 32'd8;
  assign bus.D_valid     = dvalid_q;
  assign bus.pc_misalign = mis_q;

endmodule

// File: tb/tb_f_fetch_pc.sv
// Bench for f_fetch_pc: spec-level model compared every cycle,
// plus directed literal checks.
module tb_f_fetch_pc;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   run = 1'b0;
  int   checks = 0;
  int   errors = 0;

  f_fetch_pc_if bus();

  f_fetch_pc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] im(input logic [31:0] a);
    case (a)
      32'h0000_3004: im = 32'h1000_FFFF;
      32'h0000_3010: im = 32'h0800_0C10;
      default:       im = {16'h2408, a[15:0]};
    endcase
  endfunction

  assign bus.IM_instr = im(bus.F_pc);

  // Model state: spec reset values.
  logic [31:0] m_pc = 32'h0000_3000;
  logic [31:0] m_di = 32'd0;
  logic [31:0] m_dpc = 32'd0;
  logic        m_dv = 1'b0;
  logic        m_mis = 1'b0;

  always @(posedge clk or negedge reset) begin
    logic [31:0] nxt;
    logic [31:0] off;
    logic        taken;
    if (!reset) begin
      m_pc  = 32'h0000_3000;
      m_di  = 32'd0;
      m_dpc = 32'd0;
      m_dv  = 1'b0;
      m_mis = 1'b0;
    end else if (!bus.stall) begin
      taken = m_dv && (bus.Is_JR || bus.Is_J || bus.B_jump);
      off = 32'($signed(m_di[15:0])) * 32'd4;
      if (m_dv && bus.Is_JR) begin
        nxt = bus.rs_data & 32'hFFFF_FFFC;
        if (bus.rs_data[1:0] != 2'b00) m_mis = 1'b1;
      end else if (m_dv && bus.Is_J)
        nxt = ((m_dpc + 32'd4) & 32'hF000_0000)
            | ((m_di & 32'h03FF_FFFF) << 2);
      else if (m_dv && bus.B_jump)
        nxt = m_dpc + 32'd4 + off;
      else
        nxt = m_pc + 32'd4;
`ifdef F_FETCH_PC_DELAY_SLOT_EN
      taken = 1'b0;
`endif
      m_di  = taken ? 32'd0 : im(m_pc);
      m_dv  = !taken;
      m_dpc = m_pc;
      m_pc  = nxt;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("m_F_pc", bus.F_pc, m_pc);
      chk("m_D_instr", bus.D_instr, m_di);
      chk("m_D_pc", bus.D_pc, m_dpc);
      chk("m_D_pc8", bus.D_pc8, m_dpc + 32'd8);
      chk("m_D_valid", 32'(bus.D_valid), 32'(m_dv));
      chk("m_misalign", 32'(bus.pc_misalign), 32'(m_mis));
    end
  end

  task automatic step(input logic s, input logic b,
                      input logic j, input logic jr,
                      input logic [31:0] rs);
    bus.stall   = s;
    bus.B_jump  = b;
    bus.Is_J    = j;
    bus.Is_JR   = jr;
    bus.rs_data = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stall   = 1'b0;
    bus.B_jump  = 1'b0;
    bus.Is_J    = 1'b0;
    bus.Is_JR   = 1'b0;
    bus.rs_data = 32'd0;
    #1 reset = 1'b0;
    run = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_F_pc", bus.F_pc, 32'h0000_3000);
    chk("rst_D_valid", 32'(bus.D_valid), 32'd0);
    chk("rst_D_pc8", bus.D_pc8, 32'd8);
    chk("rst_D_instr", bus.D_instr, 32'd0);
    chk("rst_mis", 32'(bus.pc_misalign), 32'd0);
    reset = 1'b1;
    // Bubble in D: B_jump must be ignored.
    step(0, 1, 0, 0, 32'd0);
    chk("seq1_F_pc", bus.F_pc, 32'h0000_3004);
    chk("seq1_D_pc", bus.D_pc, 32'h0000_3000);
    chk("seq1_D_pc8", bus.D_pc8, 32'h0000_3008);
    chk("seq1_D_valid", 32'(bus.D_valid), 32'd1);
    step(0, 0, 0, 0, 32'd0);
    chk("seq2_F_pc", bus.F_pc, 32'h0000_3008);
    chk("seq2_D_instr", bus.D_instr, 32'h1000_FFFF);
    step(0, 1, 0, 0, 32'd0);
    chk("beq_F_pc", bus.F_pc, 32'h0000_3004);
    chk("beq_D_pc", bus.D_pc, 32'h0000_3008);
`ifdef F_FETCH_PC_DELAY_SLOT_EN
    chk("beq_D_valid", 32'(bus.D_valid), 32'd1);
    chk("beq_D_instr", bus.D_instr, 32'h2408_3008);
`else
    chk("beq_D_valid", 32'(bus.D_valid), 32'd0);
    chk("beq_D_instr", bus.D_instr, 32'd0);
`endif
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 32'd0);
    chk("pre_j_D_pc", bus.D_pc, 32'h0000_3010);
    chk("pre_j_F_pc", bus.F_pc, 32'h0000_3014);
    step(0, 0, 1, 1, 32'h0000_3040);
    chk("jjr_F_pc", bus.F_pc, 32'h0000_3040);
    chk("jjr_mis", 32'(bus.pc_misalign), 32'd0);
    step(0, 0, 0, 0, 32'd0);
    chk("post_jr_D_pc", bus.D_pc, 32'h0000_3040);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 32'd0);
      chk("stall_F_pc", bus.F_pc, 32'h0000_3044);
      chk("stall_D_pc", bus.D_pc, 32'h0000_3040);
      chk("stall_D_instr", bus.D_instr, 32'h2408_3040);
    end
    step(0, 1, 0, 0, 32'd0);
    chk("unstall_F_pc", bus.F_pc, 32'h0000_F144);
    chk("unstall_D_pc", bus.D_pc, 32'h0000_3044);
    step(0, 0, 0, 0, 32'd0);
    step(0, 0, 0, 0, 32'd0);
    step(0, 0, 0, 1, 32'h0000_3006);
    chk("jr_mis_F_pc", bus.F_pc, 32'h0000_3004);
    chk("jr_mis_flag", 32'(bus.pc_misalign), 32'd1);
    step(0, 0, 0, 0, 32'd0);
    step(0, 0, 0, 0, 32'd0);
    chk("mis_sticky", 32'(bus.pc_misalign), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_F_pc", bus.F_pc, 32'h0000_3000);
    chk("async_mis", 32'(bus.pc_misalign), 32'd0);
    chk("async_D_valid", 32'(bus.D_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    step(0, 0, 0, 0, 32'd0);
    chk("rel_D_pc", bus.D_pc, 32'h0000_3000);
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_pre", bus.F_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 32'd0);
    chk("wrap_F_pc", bus.F_pc, 32'd0);
    chk("wrap_mis", 32'(bus.pc_misalign), 32'd0);
    step(0, 0, 0, 0, 32'd0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
